// File: rtl/j1_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : j1_io_pkg
//  Description : Shared constants for the J1 I/O responder: one-hot address
//                map, UART status bit positions and UART FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package j1_io_pkg;

    // One-hot I/O address map; an address may select several registers.
    localparam logic [15:0] IO_LEDS      = 16'h0001;
    localparam logic [15:0] IO_TICKS     = 16'h0004;
    localparam logic [15:0] IO_UART_DATA = 16'h1000;
    localparam logic [15:0] IO_UART_STAT = 16'h2000;

    // UART status word bit positions.
    localparam int STAT_TX_READY = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVR      = 2;
    localparam int STAT_FERR     = 3;

    // Shared by the TX and RX state machines.
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/j1_io_if.sv
`default_nettype none
// ============================================================================
//  Module      : j1_io_if
//  Description : J1 core I/O bus: read/write strobes, address, write data and
//                registered read data. The core is master, j1_io is slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface j1_io_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    modport master (output io_rd, output io_wr, output io_addr, output io_dout, input io_din);
    modport slave  (input io_rd, input io_wr, input io_addr, input io_dout, output io_din);
endinterface
`default_nettype wire

// File: rtl/j1_uart.sv
`default_nettype none
// ============================================================================
//  Module      : j1_uart
//  Description : 8N1 UART for the J1 I/O responder: TX and RX state machines,
//                2-flop input synchronizer, received byte and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module j1_uart
    import j1_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       tx_start,
    input  wire logic [7:0] tx_data,
    output logic            tx_ready,
    output logic            uart_tx,
    input  wire logic       uart_rx,
    output logic [7:0]      rx_byte,
    output logic            rx_valid,
    input  wire logic       rx_clr,
    output logic            ovr,
    output logic            ferr,
    input  wire logic       flag_clr
);
    localparam int              C_CW       = $clog2(CLKS_PER_BIT);
    localparam logic [C_CW-1:0] C_BIT_END  = C_CW'(CLKS_PER_BIT - 1);
    localparam logic [C_CW-1:0] C_HALF_END = C_CW'(CLKS_PER_BIT / 2 - 1);

    uart_state_e     r_tx_state, w_tx_state_n;
    logic [C_CW-1:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0]      r_tx_bit, w_tx_bit_n;
    logic [7:0]      r_tx_sh, w_tx_sh_n;

    uart_state_e     r_rx_state, w_rx_state_n;
    logic [C_CW-1:0] r_rx_cnt, w_rx_cnt_n;
    logic [2:0]      r_rx_bit, w_rx_bit_n;
    logic [7:0]      r_rx_sh, w_rx_sh_n;
    logic            r_rx_s1, r_rx_s2, r_rx_prev;
    logic            w_rx_done, w_rx_good;
    logic [7:0]      r_rx_byte;
    logic            r_rx_valid, r_ovr, r_ferr;

    // TX state register; a start request is only taken while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= UART_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_sh    <= w_tx_sh_n;
        end
    end

    // TX next state and line level; each bit lasts CLKS_PER_BIT cycles.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_sh_n    = r_tx_sh;
        uart_tx      = 1'b1;
        case (r_tx_state)
            UART_IDLE: begin
                if (tx_start) begin
                    w_tx_state_n = UART_START;
                    w_tx_cnt_n   = '0;
                    w_tx_sh_n    = tx_data;
                end
            end
            UART_START: begin
                uart_tx = 1'b0;
                if (r_tx_cnt == C_BIT_END) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_state_n = UART_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            UART_DATA: begin
                uart_tx = r_tx_sh[0];
                if (r_tx_cnt == C_BIT_END) begin
                    w_tx_cnt_n = '0;
                    w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
                    if (r_tx_bit == 3'd7) w_tx_state_n = UART_STOP;
                    else                  w_tx_bit_n   = r_tx_bit + 1'b1;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            UART_STOP: begin
                if (r_tx_cnt == C_BIT_END) w_tx_state_n = UART_IDLE;
                else                       w_tx_cnt_n   = r_tx_cnt + 1'b1;
            end
            default: w_tx_state_n = UART_IDLE;
        endcase
    end

    assign tx_ready = (r_tx_state == UART_IDLE);

    // RX synchronizer and state register; the line idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= UART_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_sh    <= w_rx_sh_n;
        end
    end

    // RX next state: half-bit start recheck, then mid-bit samples.
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_sh_n    = r_rx_sh;
        w_rx_done    = 1'b0;
        w_rx_good    = 1'b0;
        case (r_rx_state)
            UART_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_state_n = UART_START;
                    w_rx_cnt_n   = '0;
                end
            end
            UART_START: begin
                if (r_rx_cnt == C_HALF_END) begin
                    w_rx_cnt_n = '0;
                    w_rx_bit_n = '0;
                    w_rx_state_n = r_rx_s2 ? UART_IDLE : UART_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            UART_DATA: begin
                if (r_rx_cnt == C_BIT_END) begin
                    w_rx_cnt_n = '0;
                    w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_n = UART_STOP;
                    else                  w_rx_bit_n   = r_rx_bit + 1'b1;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            UART_STOP: begin
                if (r_rx_cnt == C_BIT_END) begin
                    w_rx_state_n = UART_IDLE;
                    w_rx_done    = 1'b1;
                    w_rx_good    = r_rx_s2;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_n = UART_IDLE;
        endcase
    end

    // Received byte and flags; a new event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (rx_clr) r_rx_valid <= 1'b0;
            if (flag_clr) begin
                r_ovr  <= 1'b0;
                r_ferr <= 1'b0;
            end
            if (w_rx_done) begin
                if (!w_rx_good) begin
                    r_ferr <= 1'b1;
                end else if (r_rx_valid && !rx_clr) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_rx_byte  <= r_rx_sh;
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    assign rx_byte  = r_rx_byte;
    assign rx_valid = r_rx_valid;
    assign ovr      = r_ovr;
    assign ferr     = r_ferr;

endmodule
`default_nettype wire

// File: rtl/j1_io.sv
`default_nettype none
// ============================================================================
//  Module      : j1_io
//  Description : Memory-mapped I/O responder for the J1 core: one-hot address
//                decode, registered read mux, LED register, UART and an
//                optional 16-bit tick counter enabled by J1_IO_TICKS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module j1_io
    import j1_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int LED_W        = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    j1_io_if.slave           bus,
    input  wire logic        uart_rx,
    output logic             uart_tx,
    output logic [LED_W-1:0] leds
);
    logic             w_sel_leds, w_sel_ticks, w_sel_data, w_sel_stat;
    logic             w_wr_ticks;
    logic             w_tx_ready, w_rx_valid, w_ovr, w_ferr;
    logic [7:0]       w_rx_byte;
    logic [15:0]      w_ticks, w_stat, w_rd_data;
    logic [LED_W-1:0] r_leds;
    logic [15:0]      r_io_din;
    logic             w_unused;

    assign w_sel_leds  = |(bus.io_addr & IO_LEDS);
    assign w_sel_ticks = |(bus.io_addr & IO_TICKS);
    assign w_sel_data  = |(bus.io_addr & IO_UART_DATA);
    assign w_sel_stat  = |(bus.io_addr & IO_UART_STAT);
    assign w_wr_ticks  = bus.io_wr && w_sel_ticks;

    j1_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk      (clk),
        .reset    (reset),
        .tx_start (bus.io_wr && w_sel_data),
        .tx_data  (bus.io_dout[7:0]),
        .tx_ready (w_tx_ready),
        .uart_tx  (uart_tx),
        .uart_rx  (uart_rx),
        .rx_byte  (w_rx_byte),
        .rx_valid (w_rx_valid),
        .rx_clr   (bus.io_rd && w_sel_data),
        .ovr      (w_ovr),
        .ferr     (w_ferr),
        .flag_clr (bus.io_rd && w_sel_stat)
    );

`ifdef J1_IO_TICKS_EN
    logic [15:0] r_ticks;

    // Free-running tick counter; a write reloads it and counting resumes next cycle.
    always_ff @(posedge clk) begin
        if (reset)           r_ticks <= '0;
        else if (w_wr_ticks) r_ticks <= bus.io_dout;
        else                 r_ticks <= r_ticks + 16'd1;
    end

    assign w_ticks = r_ticks;
`else
    assign w_ticks = '0;
`endif

    // Status word assembled from the UART flags.
    always_comb begin
        w_stat                = '0;
        w_stat[STAT_TX_READY] = w_tx_ready;
        w_stat[STAT_RX_VALID] = w_rx_valid;
        w_stat[STAT_OVR]      = w_ovr;
        w_stat[STAT_FERR]     = w_ferr;
    end

    // Read mux: OR of every selected register, zero when nothing is selected.
    always_comb begin
        w_rd_data = '0;
        if (w_sel_leds)  w_rd_data = w_rd_data | 16'(r_leds);
        if (w_sel_ticks) w_rd_data = w_rd_data | w_ticks;
        if (w_sel_data)  w_rd_data = w_rd_data | {8'h00, w_rx_byte};
        if (w_sel_stat)  w_rd_data = w_rd_data | w_stat;
    end

    // LED register and read-data register; io_din holds until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds   <= '0;
            r_io_din <= '0;
        end else begin
            if (bus.io_wr && w_sel_leds) r_leds   <= bus.io_dout[LED_W-1:0];
            if (bus.io_rd)               r_io_din <= w_rd_data;
        end
    end

    assign leds       = r_leds;
    assign bus.io_din = r_io_din;

    // Address and data bits that no register consumes.
    assign w_unused = ^{bus.io_addr, bus.io_dout, w_wr_ticks};

endmodule
`default_nettype wire

// File: tb/tb_j1_io.sv
`default_nettype none
// ============================================================================
//  Module      : tb_j1_io
//  Description : Self-checking bench for j1_io. Reads push expected data into
//                a queue that a separate monitor pops and compares; expected
//                values come from a transaction-level model of the register
//                map, the UART frame format and the flag rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_j1_io;
    localparam int C_CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic [7:0] leds;

    j1_io_if bus ();

    j1_io #(.CLKS_PER_BIT(C_CPB), .LED_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .leds    (leds)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_din = 16'h0000;

    // Reference model state
    logic [7:0]  m_leds = 8'h00;
    logic [7:0]  m_rx_byte = 8'h00;
    logic        m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
    int          m_tx_free = 0;   // first edge at which TX reads as ready
    int          m_tick_edge = 0; // edge at which ticks held m_tick_val
    logic [15:0] m_tick_val = 16'h0000;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] m_status(input int e);
        return {12'h000, m_ferr, m_ovr, m_valid, (e >= m_tx_free)};
    endfunction

    // Monitor: io_din is compared one cycle after each accepted read.
    initial begin
        forever begin
            @(posedge clk);
            if (bus.io_rd === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL io_din: read with no expected value, got %h", bus.io_din);
                end else begin
                    chk("io_din", bus.io_din, exp_q.pop_front());
                end
            end
        end
    end

    task automatic bus_op(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] dout, input logic [15:0] exp);
        bus.io_rd   = rd;
        bus.io_wr   = wr;
        bus.io_addr = addr;
        bus.io_dout = dout;
        if (rd) begin
            exp_q.push_back(exp);
            last_din = exp;
        end
        @(negedge clk);
        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
    endtask

    // One bus cycle: expected read data from the model, then model side effects.
    task automatic model_op(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] dout);
        int e;
        logic [15:0] exp;
        e = cyc + 1;
        exp = 16'h0000;
        if (addr[0]) exp = exp | {8'h00, m_leds};
`ifdef J1_IO_TICKS_EN
        if (addr[2]) exp = exp | 16'(m_tick_val + 16'(e - 1 - m_tick_edge));
`endif
        if (addr[12]) exp = exp | {8'h00, m_rx_byte};
        if (addr[13]) exp = exp | m_status(e);
        if (wr) begin
            if (addr[0]) m_leds = dout[7:0];
            if (addr[2]) begin
                m_tick_edge = e;
                m_tick_val  = dout;
            end
            if (addr[12] && e >= m_tx_free) m_tx_free = e + 10 * C_CPB + 1;
        end
        if (rd && addr[12]) m_valid = 1'b0;
        if (rd && addr[13]) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
        bus_op(rd, wr, addr, dout, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_leds = 8'h00; m_rx_byte = 8'h00;
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        m_tx_free = 0; m_tick_edge = cyc; m_tick_val = 16'h0000;
        last_din = 16'h0000;
    endtask

    // Called at the negedge right after the write edge.
    task automatic tx_frame_check(input logic [7:0] d);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int i = 0; i < 10 * C_CPB; i++) begin
            chk("uart_tx_frame", 16'(uart_tx), 16'(fr[i / C_CPB]));
            @(negedge clk);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (C_CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (2 * C_CPB) @(negedge clk);
        if (!stop)        m_ferr = 1'b1;
        else if (m_valid) m_ovr = 1'b1;
        else begin
            m_rx_byte = d;
            m_valid   = 1'b1;
        end
    endtask

    task automatic wait_tx_idle();
        while (cyc < m_tx_free - 1) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        logic [7:0]  b1, b2;
        bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_addr = 16'h0000; bus.io_dout = 16'h0000;
        repeat (3) @(negedge clk);
        do_reset();

        // Reset state
        chk("reset_uart_tx", 16'(uart_tx), 16'h0001);
        chk("reset_leds", {8'h00, leds}, 16'h0000);
        chk("reset_io_din", bus.io_din, 16'h0000);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);

        // LED register
        model_op(1'b0, 1'b1, 16'h0001, 16'h00A5);
        chk("leds_write", {8'h00, leds}, {8'h00, m_leds});
        model_op(1'b1, 1'b0, 16'h0001, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            v = 16'($urandom);
            model_op(1'b0, 1'b1, 16'h0001, v);
            chk("leds_rand", {8'h00, leds}, {8'h00, m_leds});
            model_op(1'b1, 1'b0, 16'h0001, 16'h0000);
        end

        // Unmapped addresses read 0 and ignore writes; read+write together
        model_op(1'b1, 1'b1, 16'h0100, 16'($urandom));
        model_op(1'b1, 1'b1, 16'h0000, 16'($urandom));
        chk("leds_unmapped", {8'h00, leds}, {8'h00, m_leds});
        model_op(1'b1, 1'b1, 16'h0001, 16'h005A);
        chk("leds_rdwr", {8'h00, leds}, 16'h005A);

        // TX frame of 0x55
        model_op(1'b0, 1'b1, 16'h1000, 16'h0155);
        tx_frame_check(8'h55);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);

        // Busy TX: mid-frame status, dropped second write, no second frame
        b1 = 8'($urandom);
        model_op(1'b0, 1'b1, 16'h1000, {8'h00, b1});
        repeat (6) @(negedge clk);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);
        model_op(1'b0, 1'b1, 16'h1000, 16'h0000);
        wait_tx_idle();
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);
        for (int i = 0; i < 10 * C_CPB; i++) begin
            chk("uart_tx_dropped", 16'(uart_tx), 16'h0001);
            @(negedge clk);
        end

        // Multi-select write (LEDs + TX) and OR'd multi-select read
        model_op(1'b0, 1'b1, 16'h1001, 16'h0133);
        tx_frame_check(8'h33);
        model_op(1'b1, 1'b0, 16'h2001, 16'h0000);
        chk("leds_multi", {8'h00, leds}, 16'h0033);

        // RX single frame
        send_rx(8'h3C, 1'b1);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);
        model_op(1'b1, 1'b0, 16'h1000, 16'h0000);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);

        // Overrun
        b1 = 8'($urandom); b2 = 8'($urandom);
        send_rx(b1, 1'b1);
        send_rx(b2, 1'b1);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);
        model_op(1'b1, 1'b0, 16'h1000, 16'h0000);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);

        // Framing error
        send_rx(8'($urandom), 1'b0);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);

        // One-cycle glitch is a false start
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * C_CPB) @(negedge clk);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);
        model_op(1'b1, 1'b0, 16'h1000, 16'h0000);

        // Random RX traffic with random reads
        for (int i = 0; i < 6; i++) begin
            send_rx(8'($urandom), ($urandom_range(0, 4) != 0));
            if ($urandom_range(0, 1) == 1) model_op(1'b1, 1'b0, 16'h1000, 16'h0000);
            if ($urandom_range(0, 1) == 1) model_op(1'b1, 1'b0, 16'h2000, 16'h0000);
        end
        model_op(1'b1, 1'b0, 16'h3000, 16'h0000);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);

        // Tick counter load and wrap (reads 0 when the counter is absent)
        model_op(1'b0, 1'b1, 16'h0004, 16'hFFFE);
        @(negedge clk);
        model_op(1'b1, 1'b0, 16'h0004, 16'h0000);
        model_op(1'b1, 1'b0, 16'h0004, 16'h0000);

        // io_din holds between reads
        repeat (5) @(negedge clk);
        chk("io_din_hold", bus.io_din, last_din);

        // Reset in the middle of a TX frame
        model_op(1'b0, 1'b1, 16'h1000, 16'h00F0);
        repeat (10) @(negedge clk);
        do_reset();
        chk("rst_uart_tx", 16'(uart_tx), 16'h0001);
        chk("rst_leds", {8'h00, leds}, 16'h0000);
        chk("rst_io_din", bus.io_din, 16'h0000);
        model_op(1'b1, 1'b0, 16'h0004, 16'h0000);
        model_op(1'b1, 1'b0, 16'h2000, 16'h0000);
        repeat (4) @(negedge clk);
        chk("rst_uart_tx_idle", 16'(uart_tx), 16'h0001);

        repeat (3) @(negedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
